// File: rtl/pending_priority_encoder.sv
// pending_priority_encoder
//
// Collects request pulses from WIDTH event lines into a pending set and hands
// out the binary index of one pending line per valid/ready transaction.
// When several requests arrive together they are queued and granted one at a
// time. They are never rejected as a non-one-hot input.
//
// Parameters
//   WIDTH        number of request lines (>= 2)
//   IDX_W        index width, derived from WIDTH (leave at default)
//   ROUND_ROBIN  0: lowest pending index wins
//                1: scan starts just after the last granted index, wraps at WIDTH-1
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_in     request pulses, one event per high bit per cycle
//   flush      clears pending set and output register (last_idx/overflow kept)
//   out_ready  consumer accepts out_idx this cycle
//   out_valid  out_idx holds a granted request
//   out_idx    binary index of the granted line
//   busy       anything pending or an output waiting to be accepted
//   overflow   sticky: a request hit a line that was already pending
//   clr_ovf    clears overflow; a merge in the same cycle keeps it set

module pending_priority_encoder #(
  parameter int WIDTH       = 8,
  parameter int IDX_W       = $clog2(WIDTH),
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             overflow,
  input  logic             clr_ovf
);

  logic [WIDTH-1:0] r_pend;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_overflow;
  logic [IDX_W-1:0] r_last_idx;

  logic             w_load;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_cand;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_merge;

  // (base + off) mod WIDTH for base < WIDTH and 1 <= off <= WIDTH.
  // A single conditional subtract is enough, so non-power-of-2 widths work.
  function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= WIDTH) s = s - WIDTH;
    return s[IDX_W-1:0];
  endfunction

  // The output register is free when empty or being drained this cycle.
  assign w_load = (!r_out_valid || out_ready) && (|r_pend);

  // Both selection loops walk from the least-preferred candidate to the
  // most-preferred one, so the last match that is assigned wins.
  always_comb begin
    w_sel  = '0;
    w_cand = '0;
    if (ROUND_ROBIN) begin
      for (int off = WIDTH; off >= 1; off--) begin
        w_cand = f_wrap(r_last_idx, off);
        if (r_pend[w_cand]) w_sel = w_cand;
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (r_pend[i]) w_sel = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_clr[i] = w_load && (w_sel == IDX_W'(i));
    end
  end

  // A request on the bit being granted right now re-arms it. It is not
  // counted as a merge.
  assign w_merge = req_in & r_pend & ~w_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_overflow  <= 1'b0;
      r_last_idx  <= IDX_W'(WIDTH - 1);
    end else if (flush) begin
      r_pend      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | req_in;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_idx   <= w_sel;
        r_last_idx  <= w_sel;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (|w_merge) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign overflow  = r_overflow;
  assign busy      = (|r_pend) || r_out_valid;

endmodule
